// File: rtl/store_unit_pkg.sv
// Shared store-side definitions: op encodings, byte-enable constants and the
// queue entry layout used by the store unit and its lane formatter.
package store_unit_pkg;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } st_entry_t;

    function automatic logic word_hit(input logic [29:0] entry_waddr,
                                      input logic [29:0] load_waddr);
        return (entry_waddr == load_waddr);
    endfunction

endpackage

// File: rtl/store_unit_st_format.sv
// Combinational lane formatter: replicates store data across byte lanes,
// builds byte enables and flags misaligned halfword/word stores.
module st_format
    import store_unit_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output st_entry_t   o_entry,
    output logic        o_misalign
);

    // Lane replication, byte enables and alignment check per store width
    always_comb begin
        o_entry.waddr = i_addr[31:2];
        o_entry.be    = 4'b0000;
        o_entry.wdata = 32'h0000_0000;
        o_misalign    = 1'b0;
        case (i_op)
            ST_SB: begin
                o_entry.be    = BE_BYTE << i_addr[1:0];
                o_entry.wdata = {4{i_data[7:0]}};
            end
            ST_SH: begin
                o_entry.be    = i_addr[1] ? BE_HI_HALF : BE_LO_HALF;
                o_entry.wdata = {2{i_data[15:0]}};
                o_misalign    = i_addr[0];
            end
            ST_SW: begin
                o_entry.be    = BE_WORD;
                o_entry.wdata = i_data;
                o_misalign    = (i_addr[1:0] != 2'b00);
            end
            default: begin
                o_misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: formats stores, queues aligned writes in a FIFO,
// drains them over valid/ready and flags loads overlapping queued stores.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        align_err,
    output logic [31:0] err_addr,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    st_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_occ;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_align_err;
    logic [31:0]      r_err_addr;

    st_entry_t w_entry;
    logic      w_misalign;
    logic      w_accept;
    logic      w_push;
    logic      w_pop;
    logic      w_hit;
    logic      w_unused_ld_lsbs;

    st_format u_st_format (
        .i_op       (st_op),
        .i_addr     (st_addr),
        .i_data     (st_data),
        .o_entry    (w_entry),
        .o_misalign (w_misalign)
    );

    assign st_ready  = (r_count < FULL_CNT);
    assign mem_valid = (r_count != CW'(0));
    assign empty     = (r_count == CW'(0));
    assign w_accept  = st_valid && st_ready && (st_op != ST_NONE);
    assign w_push    = w_accept && !w_misalign;
    assign w_pop     = mem_valid && mem_ready;

    assign mem_addr  = {r_mem[r_rd_ptr].waddr, 2'b00};
    assign mem_be    = r_mem[r_rd_ptr].be;
    assign mem_wdata = r_mem[r_rd_ptr].wdata;
    assign align_err = r_align_err;
    assign err_addr  = r_err_addr;

    // Queue storage; reset clears entries so the head reads back as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Occupancy, pointers and count; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_occ[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_occ[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Misalignment pulse and sticky error address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_align_err <= 1'b0;
            r_err_addr  <= 32'h0000_0000;
        end else begin
            r_align_err <= w_accept && w_misalign;
            if (w_accept && w_misalign) begin
                r_err_addr <= st_addr;
            end
        end
    end

    // Word-granular compare against occupied entries only; byte enables ignored
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit = w_hit | (r_occ[i] & word_hit(r_mem[i].waddr, ld_addr[31:2]));
        end
    end

    assign ld_hit           = ld_valid & w_hit;
    assign w_unused_ld_lsbs = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_store_unit;
    import store_unit_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        align_err;
    logic [31:0] err_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        empty;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    store_unit #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .align_err (align_err),
        .err_addr  (err_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bytes covered = [a, a+size); each lane i takes data byte (i mod size)
    function automatic exp_t fmt(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [31:0] data);
        exp_t e;
        int sz;
        int a;
        sz = (op == ST_SB) ? 1 : ((op == ST_SH) ? 2 : 4);
        a = int'(addr[1:0]);
        e.addr = {addr[31:2], 2'b00};
        e.be = 4'b0000;
        e.wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= a && i < a + sz) e.be[i] = 1'b1;
            e.wdata[8*i +: 8] = data[8*(i % sz) +: 8];
        end
        return e;
    endfunction

    function automatic bit misaligned(input logic [1:0] op, input logic [31:0] addr);
        return (op == ST_SH && addr[0]) || (op == ST_SW && addr[1:0] != 2'b00);
    endfunction

    task automatic idle();
        st_valid = 1'b0; st_op = ST_NONE; st_addr = 32'h0; st_data = 32'h0;
        mem_ready = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic drive_st(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] data);
        st_valid = 1'b1; st_op = op; st_addr = addr; st_data = data;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({mem_valid, empty, st_ready, ld_hit, align_err, err_addr, mem_addr, mem_be, mem_wdata}
            !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b e=%b r=%b h=%b ae=%b ea=%h a=%h be=%b d=%h want 0 1 1 0 0 0 0 0 0",
                     mem_valid, empty, st_ready, ld_hit, align_err, err_addr, mem_addr, mem_be, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_sb();
        do_reset();
        drive_st(ST_SB, 32'h0000_1003, 32'h0000_00AB);
        mem_ready = 1'b1;
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_valid, empty, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b0, 32'h1000, 4'b1000, 32'hABABABAB}) begin
            errors++;
            $display("FAIL sb_format: got v=%b e=%b a=%h be=%b d=%h want v=1 e=0 a=00001000 be=1000 d=abababab",
                     mem_valid, empty, mem_addr, mem_be, mem_wdata);
        end
        tick();
        checks++;
        if ({mem_valid, empty} !== 2'b01) begin
            errors++;
            $display("FAIL sb_drain: got v=%b e=%b want v=0 e=1", mem_valid, empty);
        end
    endtask

    task automatic test_sh_misalign();
        do_reset();
        drive_st(ST_SH, 32'h0000_2002, 32'h0000_1234);
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h2000, 4'b1100, 32'h12341234}) begin
            errors++;
            $display("FAIL sh_format: got v=%b a=%h be=%b d=%h want v=1 a=00002000 be=1100 d=12341234",
                     mem_valid, mem_addr, mem_be, mem_wdata);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drive_st(ST_SW, 32'h0000_2001, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (align_err !== 1'b0) begin
            errors++;
            $display("FAIL align_early: got %b want 0", align_err);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({align_err, err_addr, empty} !== {1'b1, 32'h2001, 1'b1}) begin
            errors++;
            $display("FAIL align_pulse: got err=%b addr=%h empty=%b want 1 00002001 1", align_err, err_addr, empty);
        end
        tick();
        checks++;
        if ({align_err, err_addr} !== {1'b0, 32'h2001}) begin
            errors++;
            $display("FAIL align_hold: got err=%b addr=%h want 0 00002001", align_err, err_addr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_st(ST_SW, 32'h100, 32'h1111_0000);
        tick();
        drive_st(ST_SW, 32'h104, 32'h2222_0000);
        tick();
        drive_st(ST_SW, 32'h108, 32'h3333_0000);
        #1;
        checks++;
        if (st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b want 0", st_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({st_ready, mem_valid, mem_addr, mem_wdata} !== {1'b0, 1'b1, 32'h100, 32'h1111_0000}) begin
                errors++;
                $display("FAIL stall_stable: got r=%b v=%b a=%h d=%h want 0 1 00000100 11110000",
                         st_ready, mem_valid, mem_addr, mem_wdata);
            end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (st_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: got %b want 0", st_ready);
        end
        tick();
        checks++;
        if ({st_ready, mem_addr, mem_wdata} !== {1'b1, 32'h104, 32'h2222_0000}) begin
            errors++;
            $display("FAIL order_2: got r=%b a=%h d=%h want 1 00000104 22220000", st_ready, mem_addr, mem_wdata);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'h108, 32'h3333_0000}) begin
            errors++;
            $display("FAIL order_3: got v=%b a=%h d=%h want 1 00000108 33330000", mem_valid, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_ld_hit();
        logic [31:0] addrs [3];
        logic        vals  [3];
        logic        want  [3];
        addrs = '{32'h3002, 32'h3004, 32'h3002};
        vals  = '{1'b1, 1'b1, 1'b0};
        want  = '{1'b1, 1'b0, 1'b0};
        do_reset();
        drive_st(ST_SB, 32'h3001, 32'h55);
        tick();
        st_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ld_valid = vals[k];
            ld_addr = addrs[k];
            #1;
            checks++;
            if (ld_hit !== want[k]) begin
                errors++;
                $display("FAIL ld_hit_%0d: got %b want %b", k, ld_hit, want[k]);
            end
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drive_st(ST_SW, 32'h5000, 32'h77);
        ld_valid = 1'b1;
        ld_addr = 32'h5000;
        #1;
        checks++;
        if (ld_hit !== 1'b0) begin
            errors++;
            $display("FAIL ld_hit_push: got %b want 0", ld_hit);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (ld_hit !== 1'b1) begin
            errors++;
            $display("FAIL ld_hit_after_push: got %b want 1", ld_hit);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        drive_st(ST_SW, 32'h4000, 32'hA0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            drive_st(ST_SW, 32'h4000 + 32'(4 * k), 32'hA0 + 32'(k));
            mem_ready = 1'b1;
            #1;
            checks++;
            if ({mem_valid, st_ready, mem_wdata} !== {1'b1, 1'b1, 32'hA0 + 32'(k - 1)}) begin
                errors++;
                $display("FAIL push_pop_%0d: got v=%b r=%b d=%h want 1 1 %h",
                         k, mem_valid, st_ready, mem_wdata, 32'hA0 + 32'(k - 1));
            end
            tick();
        end
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_wdata} !== {1'b1, 32'hAA}) begin
            errors++;
            $display("FAIL push_pop_last: got v=%b d=%h want 1 000000aa", mem_valid, mem_wdata);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive_st(ST_SW, 32'h7003, 32'h0);
        tick();
        drive_st(ST_SW, 32'h7000, 32'hCAFE_0001);
        tick();
        drive_st(ST_SH, 32'h7006, 32'h0000_BEEF);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr = 32'h7000;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_valid, empty, st_ready, ld_hit, align_err, err_addr, mem_addr, mem_be, mem_wdata}
            !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_drain: got v=%b e=%b r=%b h=%b ae=%b ea=%h a=%h be=%b d=%h want 0 1 1 0 0 0 0 0 0",
                     mem_valid, empty, st_ready, ld_hit, align_err, err_addr, mem_addr, mem_be, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();
        checks++;
        if ({mem_valid, empty} !== 2'b01) begin
            errors++;
            $display("FAIL reset_no_write: got v=%b e=%b want 0 1", mem_valid, empty);
        end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] exp_err_addr;
        logic        exp_err;
        bit          exp_hit;
        bit          acc;
        do_reset();
        exp_err_addr = 32'h0;
        exp_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            st_valid  = ($urandom_range(0, 3) != 0);
            st_op     = 2'($urandom_range(0, 3));
            st_addr   = 32'h6000 + 32'($urandom_range(0, 23));
            st_data   = $urandom;
            mem_ready = ($urandom_range(0, 1) != 0);
            ld_valid  = ($urandom_range(0, 1) != 0);
            ld_addr   = 32'h6000 + 32'($urandom_range(0, 23));
            #1;
            exp_hit = 1'b0;
            foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) exp_hit = 1'b1;
            exp_hit = exp_hit && ld_valid;
            checks++;
            if ({mem_valid, empty, st_ready, ld_hit, align_err, err_addr}
                !== {q.size() != 0, q.size() == 0, q.size() < DEPTH, exp_hit, exp_err, exp_err_addr}) begin
                errors++;
                $display("FAIL rand_ctrl_%0d: got v=%b e=%b r=%b h=%b ae=%b ea=%h want v=%b e=%b r=%b h=%b ae=%b ea=%h",
                         c, mem_valid, empty, st_ready, ld_hit, align_err, err_addr,
                         q.size() != 0, q.size() == 0, q.size() < DEPTH, exp_hit, exp_err, exp_err_addr);
            end
            if (q.size() != 0) begin
                checks++;
                if ({mem_addr, mem_be, mem_wdata} !== {q[0].addr, q[0].be, q[0].wdata}) begin
                    errors++;
                    $display("FAIL rand_head_%0d: got a=%h be=%b d=%h want a=%h be=%b d=%h",
                             c, mem_addr, mem_be, mem_wdata, q[0].addr, q[0].be, q[0].wdata);
                end
            end
            acc = st_valid && (q.size() < DEPTH) && (st_op != ST_NONE);
            e = fmt(st_op, st_addr, st_data);
            exp_err = acc && misaligned(st_op, st_addr);
            if (exp_err) exp_err_addr = st_addr;
            tick();
            if (mem_ready && q.size() != 0) void'(q.pop_front());
            if (acc && !misaligned(st_op, st_addr)) q.push_back(e);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        test_reset();
        test_sb();
        test_sh_misalign();
        test_back_to_back();
        test_ld_hit();
        test_push_pop();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
